// File: rtl/rv32_mem_bus.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_bus
// Description : RV32 memory stage driving a valid/ready data bus with wait
//               states. Builds little-endian byte masks, lane-shifts store
//               data, extracts and extends load data, stalls the pipeline
//               while an access is in flight and optionally aborts hung
//               accesses after BUS_TIMEOUT cycles.
//               Optional feature macro: RV32_MEM_MISALIGN_TRAP_EN
//               (trap misaligned half/word accesses instead of issuing them).
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mem_bus #(
    parameter int ADDR_WIDTH   = 32,
    parameter int BUS_TIMEOUT  = 0,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  read_en_in,
    input  logic                  write_en_in,
    input  logic [1:0]            width_in,
    input  logic                  zero_extend_in,
    input  logic [4:0]            rd_in,
    input  logic                  rd_writeback_in,
    input  logic [ADDR_WIDTH-1:0] result_in,
    input  logic [31:0]           rs2_value_in,
    output logic                  stall_out,
    output logic                  bus_valid_out,
    input  logic                  bus_ready_in,
    output logic                  bus_write_out,
    output logic [ADDR_WIDTH-1:0] bus_addr_out,
    output logic [3:0]            bus_write_mask_out,
    output logic [31:0]           bus_write_value_out,
    input  logic [31:0]           bus_read_value_in,
    output logic [4:0]            rd_out,
    output logic                  rd_writeback_out,
    output logic [31:0]           rd_value_out,
    output logic                  fault_out,
    output logic                  misaligned_out
);

    localparam logic [1:0] c_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] c_WIDTH_HALF = 2'b01;
    localparam logic       c_TO_EN      = (BUS_TIMEOUT > 0);
    localparam logic [TIMEOUT_BITS-1:0] c_TO_LAST =
        (BUS_TIMEOUT > 0) ? TIMEOUT_BITS'(BUS_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [31:0]             w_result32;
    logic                    w_mem_op, w_misaligned, w_req;
    logic [3:0]              w_mask;
    logic [31:0]             w_wdata;
    logic                    w_stall, w_complete, w_timeout, w_update, w_fault_now;
    logic [31:0]             w_raw, w_load;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [TIMEOUT_BITS-1:0] r_wait_cnt;
    logic                    r_kill, r_fault_pend;
    logic [31:0]             r_hold;
    logic [4:0]              r_rd;
    logic                    r_wb, r_is_load, r_zext;
    logic [1:0]              r_width, r_off;
    logic [31:0]             r_result;

    // Non-memory results are 32-bit values regardless of the address width
    generate
        if (ADDR_WIDTH >= 32) begin : g_res_trunc
            assign w_result32 = result_in[31:0];
        end else begin : g_res_ext
            assign w_result32 = {{(32 - ADDR_WIDTH){1'b0}}, result_in};
        end
    endgenerate

    assign w_mem_op = read_en_in | write_en_in;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_mem_op & ~flush_in &
        (((width_in == c_WIDTH_HALF) & result_in[0]) |
         ((width_in != c_WIDTH_HALF) & (width_in != c_WIDTH_BYTE) & (result_in[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_req = w_mem_op & ~flush_in & ~w_misaligned;

    // Store byte enables and lane-replicated store data
    always_comb begin
        w_mask  = 4'hF;
        w_wdata = rs2_value_in;
        case (width_in)
            c_WIDTH_BYTE: begin
                w_mask  = 4'b0001 << result_in[1:0];
                w_wdata = {4{rs2_value_in[7:0]}};
            end
            c_WIDTH_HALF: begin
                w_mask  = result_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_value_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data comes straight off the bus on completion, or from the holding reg in DONE
    assign w_raw = (r_state == S_DONE) ? r_hold : bus_read_value_in;

    // Lane selection and sign/zero extension of load data
    always_comb begin
        w_byte = w_raw[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? w_raw[31:16] : w_raw[15:0];
        w_load = w_raw;
        case (r_width)
            c_WIDTH_BYTE: w_load = {{24{w_byte[7] & ~r_zext}}, w_byte};
            c_WIDTH_HALF: w_load = {{16{w_half[15] & ~r_zext}}, w_half};
            default:      w_load = w_raw;
        endcase
    end

    assign w_timeout = c_TO_EN & (r_state == S_BUSY) & ~bus_ready_in & (r_wait_cnt == c_TO_LAST);

    // Next-state and stall decode
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next  = S_BUSY;
                    w_stall = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus_ready_in | w_timeout) begin
                    w_complete = 1'b1;
                    w_next     = stall_in ? S_DONE : S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_DONE: begin
                if (!stall_in) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign stall_out   = w_stall;
    assign w_update    = ~stall_in & ~w_stall;
    assign w_fault_now = (r_state == S_BUSY) ? w_timeout : r_fault_pend;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Bus request, access bookkeeping and stage output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_valid_out       <= 1'b0;
            bus_write_out       <= 1'b0;
            bus_addr_out        <= '0;
            bus_write_mask_out  <= 4'h0;
            bus_write_value_out <= 32'h0;
            r_wait_cnt          <= '0;
            r_kill              <= 1'b0;
            r_fault_pend        <= 1'b0;
            r_hold              <= 32'h0;
            r_rd                <= 5'd0;
            r_wb                <= 1'b0;
            r_is_load           <= 1'b0;
            r_zext              <= 1'b0;
            r_width             <= 2'b00;
            r_off               <= 2'b00;
            r_result            <= 32'h0;
            rd_out              <= 5'd0;
            rd_writeback_out    <= 1'b0;
            rd_value_out        <= 32'h0;
            fault_out           <= 1'b0;
            misaligned_out      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                bus_valid_out       <= 1'b1;
                bus_write_out       <= write_en_in;
                bus_addr_out        <= {result_in[ADDR_WIDTH-1:2], 2'b00};
                bus_write_mask_out  <= write_en_in ? w_mask : 4'h0;
                bus_write_value_out <= w_wdata;
                r_wait_cnt          <= '0;
                r_kill              <= 1'b0;
                r_fault_pend        <= 1'b0;
                r_rd                <= rd_in;
                r_wb                <= rd_writeback_in;
                r_is_load           <= read_en_in;
                r_zext              <= zero_extend_in;
                r_width             <= width_in;
                r_off               <= result_in[1:0];
                r_result            <= w_result32;
            end
            if (r_state == S_BUSY) begin
                if (w_complete) begin
                    bus_valid_out      <= 1'b0;
                    bus_write_out      <= 1'b0;
                    bus_write_mask_out <= 4'h0;
                    r_hold             <= bus_read_value_in;
                    r_fault_pend       <= w_timeout;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
            if (r_state != S_IDLE && flush_in) r_kill <= 1'b1;
            if (w_update) begin
                if (r_state == S_IDLE) begin
                    rd_out           <= rd_in;
                    rd_writeback_out <= rd_writeback_in & ~flush_in & ~w_misaligned;
                    rd_value_out     <= w_result32;
                    fault_out        <= 1'b0;
                    misaligned_out   <= w_misaligned;
                end else begin
                    rd_out           <= r_rd;
                    rd_writeback_out <= r_wb & ~r_kill & ~flush_in & ~w_fault_now;
                    rd_value_out     <= r_is_load ? w_load : r_result;
                    fault_out        <= w_fault_now;
                    misaligned_out   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_mem_bus
// Description : Self-checking bench for rv32_mem_bus. A transaction-level
//               model predicts bus requests, stalls and retired values; a
//               negedge process compares every cycle, plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_bus;
    localparam int TO = 4;
    localparam logic [1:0] W_B = 2'd0, W_H = 2'd1, W_W = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n, stall_in, flush_in, read_en_in, write_en_in, zero_extend_in;
    logic [1:0]  width_in;
    logic [4:0]  rd_in;
    logic        rd_writeback_in, bus_ready_in;
    logic [31:0] result_in, rs2_value_in, bus_read_value_in;
    logic        stall_out, bus_valid_out, bus_write_out;
    logic [31:0] bus_addr_out, bus_write_value_out, rd_value_out;
    logic [3:0]  bus_write_mask_out;
    logic [4:0]  rd_out;
    logic        rd_writeback_out, fault_out, misaligned_out;

    always #5 clk = ~clk;

    rv32_mem_bus #(.ADDR_WIDTH(32), .BUS_TIMEOUT(TO), .TIMEOUT_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .read_en_in(read_en_in), .write_en_in(write_en_in), .width_in(width_in),
        .zero_extend_in(zero_extend_in), .rd_in(rd_in), .rd_writeback_in(rd_writeback_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in), .stall_out(stall_out),
        .bus_valid_out(bus_valid_out), .bus_ready_in(bus_ready_in), .bus_write_out(bus_write_out),
        .bus_addr_out(bus_addr_out), .bus_write_mask_out(bus_write_mask_out),
        .bus_write_value_out(bus_write_value_out), .bus_read_value_in(bus_read_value_in),
        .rd_out(rd_out), .rd_writeback_out(rd_writeback_out), .rd_value_out(rd_value_out),
        .fault_out(fault_out), .misaligned_out(misaligned_out)
    );

    int total = 0, bad = 0;
    logic        check_en = 1'b0;
    logic        exp_stall, exp_valid, exp_write, exp_wb, exp_fault, exp_mis, exp_care;
    logic [31:0] exp_addr, exp_wdata, exp_val;
    logic [3:0]  exp_mask;
    logic [4:0]  exp_rd;
    int          stall_cnt = 0, valid_cnt = 0;
    logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0;
    logic [3:0]  seen_mask = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Spec-level store byte enables
    function automatic logic [3:0] m_mask(input logic [1:0] w, input logic [1:0] off);
        if (w == W_B)      return 4'b0001 << off;
        else if (w == W_H) return off[1] ? 4'b1100 : 4'b0011;
        else               return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] v);
        if (w == W_B)      return {4{v[7:0]}};
        else if (w == W_H) return {2{v[15:0]}};
        else               return v;
    endfunction

    // Spec-level load extraction with plain shifts and masks
    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [1:0] w,
                                           input logic [1:0] off, input logic zx);
        logic [31:0] v;
        if (w == W_B) begin
            v = (d >> (8 * int'(off))) & 32'hFF;
            if (!zx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == W_H) begin
            v = (off[1] ? (d >> 16) : d) & 32'hFFFF;
            if (!zx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Per-cycle comparison of DUT outputs against the model expectations
    always @(negedge clk) begin
        if (check_en) begin
            check("stall_out", 32'(stall_out), 32'(exp_stall));
            check("bus_valid", 32'(bus_valid_out), 32'(exp_valid));
            if (exp_valid) begin
                check("bus_addr", bus_addr_out, exp_addr);
                check("bus_write", 32'(bus_write_out), 32'(exp_write));
                if (exp_write) begin
                    check("bus_mask", 32'(bus_write_mask_out), 32'(exp_mask));
                    check("bus_wdata", bus_write_value_out, exp_wdata);
                end
            end
            check("rd_out", 32'(rd_out), 32'(exp_rd));
            check("rd_wb", 32'(rd_writeback_out), 32'(exp_wb));
            check("fault", 32'(fault_out), 32'(exp_fault));
            check("misaligned", 32'(misaligned_out), 32'(exp_mis));
            if (exp_care) check("rd_value", rd_value_out, exp_val);
        end
        if (stall_out === 1'b1) stall_cnt++;
        if (bus_valid_out === 1'b1) begin
            valid_cnt++;
            seen_addr  = bus_addr_out;
            seen_mask  = bus_write_mask_out;
            seen_wdata = bus_write_value_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [4:0] rd, input logic wb, input logic [31:0] v,
                           input logic f, input logic m, input logic care);
        exp_rd = rd; exp_wb = wb; exp_val = v; exp_fault = f; exp_mis = m; exp_care = care;
    endtask

    // Presents one instruction and walks it to retirement.
    // lat: BUSY cycle on which ready is given; dstall: forced stall cycles from completion;
    // flush_at: 0 = flushed on entry, k>0 = one-cycle flush on access cycle k, -1 = none.
    task automatic run_op(input logic rdn, input logic wrn, input logic [1:0] w, input logic zx,
                          input logic [4:0] rd, input logic wbi, input logic [31:0] res,
                          input logic [31:0] rs2, input int lat, input int spct, input int dstall,
                          input int flush_at, input logic fixd, input logic [31:0] fix_data);
        logic mem, mis, f0, killed, timed, done, st;
        logic [31:0] rdata;
        int k, hold, guard;
        mem = rdn | wrn;
        f0  = (flush_at == 0);
        mis = 1'b0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        mis = mem && !f0 && ((w == W_H && res[0]) || (w == W_W && res[1:0] != 2'b00));
`endif
        read_en_in = rdn; write_en_in = wrn; width_in = w; zero_extend_in = zx;
        rd_in = rd; rd_writeback_in = wbi; result_in = res; rs2_value_in = rs2;
        bus_ready_in = 1'b0; flush_in = f0;
        exp_addr = {res[31:2], 2'b00}; exp_write = wrn;
        exp_mask = m_mask(w, res[1:0]); exp_wdata = m_wdata(w, rs2);
        if (!mem || f0 || mis) begin
            guard = 0;
            st = 1'b1;
            while (st) begin
                st = (guard < 20) && ($urandom_range(99) < spct);
                stall_in = st; exp_stall = 1'b0; exp_valid = 1'b0;
                bus_read_value_in = $urandom;
                tick();
                guard++;
            end
            set_exp(rd, wbi && !f0 && !mis, res, 1'b0, mis, 1'b1);
        end else begin
            stall_in = ($urandom_range(99) < spct); exp_stall = 1'b1; exp_valid = 1'b0;
            bus_read_value_in = $urandom;
            tick();
            killed = 1'b0; timed = 1'b0; done = 1'b0; hold = dstall; k = 1; st = 1'b0;
            rdata = 32'h0;
            while (!done && k <= 50) begin
                flush_in = (k == flush_at); killed = killed | flush_in;
                bus_ready_in = (k == lat);
                timed = (k == TO) && !bus_ready_in;
                done  = bus_ready_in || timed;
                rdata = fixd ? fix_data : $urandom;
                bus_read_value_in = rdata;
                exp_valid = 1'b1; exp_stall = !done;
                st = (done && hold > 0) ? 1'b1 : ($urandom_range(99) < spct);
                if (done && hold > 0) hold--;
                stall_in = st;
                tick();
                k++;
            end
            if (!done) begin
                total++; bad++;
                $display("FAIL bus_done_bound: no completion, required one within %0d cycles", TO);
            end
            bus_ready_in = 1'b0; exp_valid = 1'b0; exp_stall = 1'b0;
            guard = 0;
            while (done && st) begin
                flush_in = (k == flush_at); killed = killed | flush_in;
                st = (hold > 0) ? 1'b1 : ((guard < 20) && ($urandom_range(99) < spct));
                if (hold > 0) hold--;
                stall_in = st;
                bus_read_value_in = $urandom;
                tick();
                k++; guard++;
            end
            set_exp(rd, wbi && !killed && !timed,
                    rdn ? m_load(rdata, w, res[1:0], zx) : res, timed, 1'b0, !(timed && rdn));
        end
        flush_in = 1'b0;
    endtask

    int sbase, vbase;
    int kind, fa;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0; read_en_in = 1'b0; write_en_in = 1'b0;
        width_in = W_W; zero_extend_in = 1'b0; rd_in = 5'd0; rd_writeback_in = 1'b0;
        result_in = 32'h0; rs2_value_in = 32'h0; bus_ready_in = 1'b0; bus_read_value_in = 32'h0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_write = 1'b0; exp_addr = 32'h0; exp_mask = 4'h0;
        exp_wdata = 32'h0;
        set_exp(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check("rst_valid", 32'(bus_valid_out), 32'h0);
        check("rst_rd_value", rd_value_out, 32'h0);
        check("rst_wb", 32'(rd_writeback_out), 32'h0);
        check("rst_fault", 32'(fault_out), 32'h0);
        reset_n = 1'b1;
        check_en = 1'b1;

        // SW 0xDEADBEEF @0x100, ready on third access cycle
        sbase = stall_cnt;
        run_op(0, 1, W_W, 0, 5'd7, 1, 32'h100, 32'hDEAD_BEEF, 3, 0, 0, -1, 0, 0);
        check("sw_stall_cycles", 32'(stall_cnt - sbase), 32'd3);
        check("sw_mask", 32'(seen_mask), 32'hF);
        check("sw_addr", seen_addr, 32'h100);
        check("sw_retire_value", rd_value_out, 32'h100);
        check("sw_retire_wb", 32'(rd_writeback_out), 32'h1);

        // Sign/zero-extended byte and half loads
        run_op(1, 0, W_B, 0, 5'd3, 1, 32'h103, 0, 1, 0, 0, -1, 1, 32'h80FF_0000);
        check("lb_value", rd_value_out, 32'hFFFF_FF80);
        run_op(1, 0, W_B, 1, 5'd3, 1, 32'h103, 0, 2, 0, 0, -1, 1, 32'h80FF_0000);
        check("lbu_value", rd_value_out, 32'h0000_0080);
        run_op(1, 0, W_H, 0, 5'd4, 1, 32'h102, 0, 1, 0, 0, -1, 1, 32'h80FF_0000);
        check("lh_value", rd_value_out, 32'hFFFF_80FF);

        // Sub-word stores
        run_op(0, 1, W_B, 0, 5'd0, 0, 32'h101, 32'h0000_00AB, 1, 0, 0, -1, 0, 0);
        check("sb_mask", 32'(seen_mask), 32'h2);
        check("sb_lane", 32'(seen_wdata[15:8]), 32'hAB);
        run_op(0, 1, W_H, 0, 5'd0, 0, 32'h102, 32'h0000_1234, 2, 0, 0, -1, 0, 0);
        check("sh_mask", 32'(seen_mask), 32'hC);

        // LW completing under downstream stall for 2 cycles
        run_op(1, 0, W_W, 0, 5'd9, 1, 32'h200, 0, 2, 0, 2, -1, 1, 32'h1234_5678);
        check("lw_done_value", rd_value_out, 32'h1234_5678);

        // Hung access aborted by timeout
        sbase = stall_cnt;
        run_op(1, 0, W_W, 0, 5'd10, 1, 32'h300, 0, 99, 0, 0, -1, 0, 0);
        check("to_stall_cycles", 32'(stall_cnt - sbase), 32'd4);
        check("to_fault", 32'(fault_out), 32'h1);
        check("to_wb", 32'(rd_writeback_out), 32'h0);

        // Flush in the middle of an access
        run_op(1, 0, W_W, 0, 5'd11, 1, 32'h400, 0, 3, 0, 0, 2, 0, 0);
        check("flush_wb", 32'(rd_writeback_out), 32'h0);

        // Misaligned word
        vbase = valid_cnt;
        run_op(1, 0, W_W, 0, 5'd12, 1, 32'h102, 0, 1, 0, 0, -1, 0, 0);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        check("mis_no_bus", 32'(valid_cnt - vbase), 32'd0);
        check("mis_flag", 32'(misaligned_out), 32'h1);
`else
        check("mis_addr", seen_addr, 32'h100);
        check("mis_flag", 32'(misaligned_out), 32'h0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(2);
            fa   = ($urandom_range(9) == 0) ? $urandom_range(4) : -1;
            run_op(kind == 1, kind == 2, 2'($urandom_range(2)), 1'($urandom_range(1)),
                   5'($urandom), 1'($urandom_range(1)), $urandom, $urandom,
                   $urandom_range(1, 5), 30, 0, fa, 0, 0);
        end

        // Reset in the middle of an access
        check_en = 1'b0;
        stall_in = 1'b0;
        read_en_in = 1'b1; write_en_in = 1'b0; width_in = W_W; result_in = 32'h500; flush_in = 1'b0;
        tick();
        tick();
        check("pre_reset_valid", 32'(bus_valid_out), 32'h1);
        reset_n = 1'b0; read_en_in = 1'b0;
        tick();
        check("reset_drop_valid", 32'(bus_valid_out), 32'h0);
        check("reset_drop_stall", 32'(stall_out), 32'h0);
        check("reset_drop_wb", 32'(rd_writeback_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
